// File: rtl/coef_readback.sv
// Purpose: snapshot a packed weight table on start and stream taps 2..NTAP+1 as valid/ready words.
// Latency: first word (idx 2) presented the cycle after the accepted start edge, one word per cycle thereafter.
// Backpressure: out_ready low holds out_data/out_idx/out_last stable; start is ignored while busy.
// Optional checksum stage enabled by defining COEF_RB_CHECKSUM_EN.
module coef_readback #(
  parameter int NTAP = 15,
  parameter int WD   = 10
) (
  input  logic               clk,
  input  logic               r,
  input  logic               start,
  input  logic [NTAP*WD-1:0] w_bus,
  output logic [WD-1:0]      out_data,
  output logic [4:0]         out_idx,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_last,
  output logic               busy,
  output logic [13:0]        chk,
  output logic               chk_valid
);

  localparam int PW = (NTAP > 1) ? $clog2(NTAP) : 1;
  localparam logic [PW-1:0] LAST_POS = PW'(NTAP - 1);

`ifdef COEF_RB_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE, SEND, CHK} state_t;
`else
  typedef enum logic {IDLE, SEND} state_t;
`endif

  state_t                  state, state_nxt;
  logic [NTAP-1:0][WD-1:0] snap;
  logic [PW-1:0]           pos;     // position in the table; out_idx = pos + 2
  logic                    accept;
  logic                    xfer;
  logic                    last_xfer;

  assign accept    = (state == IDLE) && start;
  assign xfer      = out_valid && out_ready;
  assign last_xfer = xfer && (pos == LAST_POS);

  // State register, cleared asynchronously so a reset abandons any stream.
  always_ff @(posedge clk or negedge r) begin
    if (!r) state <= IDLE;
    else    state <= state_nxt;
  end

  // Next-state and status outputs.
  always_comb begin
    state_nxt = state;
    out_valid = 1'b0;
    busy      = 1'b0;
`ifdef COEF_RB_CHECKSUM_EN
    chk_valid = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (start) state_nxt = SEND;
      end
      SEND: begin
        out_valid = 1'b1;
        busy      = 1'b1;
`ifdef COEF_RB_CHECKSUM_EN
        if (last_xfer) state_nxt = CHK;
`else
        if (last_xfer) state_nxt = IDLE;
`endif
      end
`ifdef COEF_RB_CHECKSUM_EN
      CHK: begin
        busy      = 1'b1;
        chk_valid = 1'b1;
        state_nxt = IDLE;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // Snapshot capture on accepted start; position advances once per transfer.
  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      snap <= '0;
      pos  <= '0;
    end else if (accept) begin
      snap <= w_bus;
      pos  <= '0;
    end else if (xfer) begin
      pos  <= last_xfer ? '0 : pos + PW'(1);
    end
  end

  // Word outputs read zero whenever nothing is presented.
  assign out_data = out_valid ? snap[pos] : '0;
  assign out_idx  = out_valid ? (5'(pos) + 5'd2) : 5'd0;
  assign out_last = out_valid && (pos == LAST_POS);

`ifdef COEF_RB_CHECKSUM_EN
  logic [13:0] acc;

  // Running sum of transferred words, restarted by each accepted start.
  always_ff @(posedge clk or negedge r) begin
    if (!r)          acc <= '0;
    else if (accept) acc <= '0;
    else if (xfer)   acc <= acc + 14'(out_data);
  end

  assign chk = acc;
`else
  assign chk       = '0;
  assign chk_valid = 1'b0;
`endif

endmodule

// File: tb/tb_coef_readback.sv
// Bench for coef_readback: randomized streams against a table-level reference model,
// plus literal expectations for reset, latency, ordering, capture and checksum.
module tb_coef_readback;
  localparam int NTAP = 15;
  localparam int WD   = 10;
  localparam int W    = NTAP * WD;
`ifdef COEF_RB_CHECKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          r = 1'b1;
  logic          start = 1'b0;
  logic          out_ready = 1'b0;
  logic [W-1:0]  w_bus = '0;
  logic [WD-1:0] out_data;
  logic [4:0]    out_idx;
  logic          out_valid;
  logic          out_last;
  logic          busy;
  logic [13:0]   chk;
  logic          chk_valid;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;
  int q_idx[$];
  int q_dat[$];

  coef_readback #(.NTAP(NTAP), .WD(WD)) dut (
    .clk(clk), .r(r), .start(start), .w_bus(w_bus),
    .out_data(out_data), .out_idx(out_idx), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .busy(busy),
    .chk(chk), .chk_valid(chk_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a stream is "a table captured at start plus a count of words delivered".
  bit          m_active = 1'b0;
  bit          m_chkph  = 1'b0;
  int          m_n      = 0;
  logic [13:0] m_sum    = '0;
  logic [WD-1:0] m_snap [NTAP];

  always @(posedge clk or negedge r) begin
    if (!r) begin
      m_active <= 1'b0;
      m_chkph  <= 1'b0;
      m_n      <= 0;
      m_sum    <= '0;
    end else begin
      if (m_chkph) m_chkph <= 1'b0;
      if (!m_active && !m_chkph) begin
        if (start) begin
          m_active <= 1'b1;
          m_n      <= 0;
          m_sum    <= '0;
          for (int i = 0; i < NTAP; i++) m_snap[i] <= w_bus[i*WD +: WD];
        end
      end else if (m_active && out_ready) begin
        m_sum <= m_sum + 14'(m_snap[m_n]);
        if (m_n == NTAP - 1) begin
          m_active <= 1'b0;
          m_chkph  <= CHK_EN;
          m_n      <= 0;
        end else begin
          m_n <= m_n + 1;
        end
      end
    end
  end

  // Every-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("out_valid", 32'(out_valid), 32'(m_active));
      check("out_idx",   32'(out_idx),   m_active ? m_n + 2 : 0);
      check("out_data",  32'(out_data),  m_active ? 32'(m_snap[m_n]) : 0);
      check("out_last",  32'(out_last),  32'(m_active && (m_n == NTAP - 1)));
      check("busy",      32'(busy),      32'(m_active || m_chkph));
      check("chk_valid", 32'(chk_valid), 32'(m_chkph));
      check("chk",       32'(chk),       CHK_EN ? 32'(m_sum) : 0);
    end
  end

  // rmode: 0 ready always, 1 ready toggles starting high, 2 random.
  task automatic run_stream(input logic [W-1:0] w, input int rmode, input bit clobber,
                            input bit noise, input bit immediate, output int ncyc);
    bit done;
    done = 1'b0;
    ncyc = 0;
    q_idx.delete();
    q_dat.delete();
    if (!immediate) @(negedge clk);
    w_bus = w;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (clobber) w_bus = '1;
    check("first_valid", 32'(out_valid), 1);
    check("first_idx", 32'(out_idx), 2);
    for (int c = 0; c < 400 && !done; c++) begin
      case (rmode)
        0:       out_ready = 1'b1;
        1:       out_ready = (c % 2 == 0);
        default: out_ready = ($urandom_range(0, 1) == 1);
      endcase
      start = noise ? ($urandom_range(0, 1) == 1) : 1'b0;
      if (out_valid && out_ready) begin
        q_idx.push_back(32'(out_idx));
        q_dat.push_back(32'(out_data));
        if (out_last) begin
          done = 1'b1;
          if (noise) start = 1'b1;
        end
      end
      @(negedge clk);
      ncyc++;
    end
    start = 1'b0;
    check("stream_done", 32'(done), 1);
    check("post_valid", 32'(out_valid), 0);
    check("post_busy", 32'(busy), 32'(CHK_EN));
    check("post_chk_valid", 32'(chk_valid), 32'(CHK_EN));
    for (int c = 0; c < 10 && busy; c++) @(negedge clk);
    check("idle_after", 32'(busy), 0);
    check("xfer_count", q_idx.size(), NTAP);
    for (int i = 0; i < q_idx.size() && i < NTAP; i++) begin
      check("xfer_idx", q_idx[i], i + 2);
      check("xfer_data", q_dat[i], 32'(w[i*WD +: WD]));
    end
  endtask

  initial begin
    logic [W-1:0] w1;
    logic [W-1:0] wr;
    int n;
    #2 r = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_out_idx", 32'(out_idx), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_last", 32'(out_last), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_chk", 32'(chk), 0);
    check("rst_chk_valid", 32'(chk_valid), 0);
    r = 1'b1;
    cmp_en = 1'b1;

    for (int i = 0; i < NTAP; i++) w1[i*WD +: WD] = WD'(i + 1);

    // Taps hold 1..15, sink always ready: 15 back-to-back words.
    run_stream(w1, 0, 1'b0, 1'b0, 1'b0, n);
    check("burst_cycles", n, NTAP);
    for (int i = 0; i < q_dat.size(); i++) check("t1_word", q_dat[i], i + 1);

    // Ready toggling: each word held one stalled cycle.
    run_stream(w1, 1, 1'b0, 1'b0, 1'b0, n);
    check("toggle_cycles", n, 2 * NTAP - 1);

    // Table overwritten after start: captured values still stream.
    run_stream(w1, 0, 1'b1, 1'b0, 1'b0, n);
    for (int i = 0; i < q_dat.size(); i++) check("t3_word", q_dat[i], i + 1);

    // Start noise during the stream and on the final transfer, then start right after.
    for (int i = 0; i < NTAP; i++) wr[i*WD +: WD] = WD'($urandom);
    run_stream(wr, 2, 1'b0, 1'b1, 1'b0, n);
    run_stream(w1, 0, 1'b0, 1'b0, 1'b1, n);

    // All-ones table: checksum 15 * 1023.
    run_stream('1, 0, 1'b0, 1'b0, 1'b0, n);
    check("chk_sum", 32'(chk), CHK_EN ? 15345 : 0);

    // Randomized streams.
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < NTAP; i++) wr[i*WD +: WD] = WD'($urandom);
      run_stream(wr, 2, ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1), 1'b0, n);
    end

    // Reset mid-stream at idx 7.
    for (int i = 0; i < NTAP; i++) wr[i*WD +: WD] = WD'($urandom);
    @(negedge clk);
    w_bus = wr;
    start = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 40 && out_idx != 5'd7; c++) @(negedge clk);
    check("reached_idx7", 32'(out_idx), 7);
    #2 r = 1'b0;
    #1;
    check("arst_out_data", 32'(out_data), 0);
    check("arst_out_idx", 32'(out_idx), 0);
    check("arst_out_valid", 32'(out_valid), 0);
    check("arst_out_last", 32'(out_last), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_chk", 32'(chk), 0);
    check("arst_chk_valid", 32'(chk_valid), 0);
    repeat (2) @(negedge clk);
    r = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("post_rst_valid", 32'(out_valid), 0);
      check("post_rst_idx", 32'(out_idx), 0);
    end

    // Recovery after reset.
    run_stream(w1, 2, 1'b0, 1'b0, 1'b0, n);

    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
